// File: rtl/lift_pkg.sv
// Shared types and constants for the N-floor SCAN lift controller.
package lift_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DOOR
  } lift_state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/lift_req_scan.sv
// Combinational scan of the pending-request vector relative to the car:
// reports whether any request lies above, below, or at the current floor.
module lift_req_scan
  import lift_pkg::*;
#(
  parameter  int NUM_FLOORS = 8,
  localparam int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic                  any_above,
  output logic                  any_below,
  output logic                  hit
);

  // Classify every outstanding request against the current floor.
  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
      if (pending[f] && (FLOOR_W'(f) > cur_floor)) any_above = 1'b1;
      if (pending[f] && (FLOOR_W'(f) < cur_floor)) any_below = 1'b1;
    end
    hit = pending[cur_floor];
  end

endmodule

// File: rtl/lift_ctrl_n.sv
// N-floor lift controller: latches floor requests and serves them in SCAN
// order, one floor per MOVE_CYCLES clocks, door open DOOR_CYCLES clocks.
// Optional feature macro: LIFT_CTRL_HOLD_EN adds the door_hold input, which
// keeps the door open while asserted.
module lift_ctrl_n
  import lift_pkg::*;
#(
  parameter  int NUM_FLOORS  = 8,
  parameter  int MOVE_CYCLES = 4,
  parameter  int DOOR_CYCLES = 6,
  localparam int FLOOR_W     = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef LIFT_CTRL_HOLD_EN
  input  logic                  door_hold,
`endif
  input  logic [NUM_FLOORS-1:0] req_vec,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic [NUM_FLOORS-1:0] floor_onehot,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TIMER_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam logic [TIMER_W-1:0] MOVE_RELOAD = TIMER_W'(MOVE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_RELOAD = TIMER_W'(DOOR_CYCLES - 1);

  lift_state_e             state_q;
  logic [TIMER_W-1:0]      timer_q;
  logic [FLOOR_W-1:0]      floor_q;
  logic                    dir_q;
  logic [NUM_FLOORS-1:0]   pending_q;
  logic [NUM_FLOORS-1:0]   pending_d;
  logic [NUM_FLOORS-1:0]   clear_mask;
  logic [FLOOR_W-1:0]      step_floor;
  logic                    arrive;
  logic                    enter_door;
  logic                    any_above;
  logic                    any_below;
  logic                    hit;
  logic                    hold;

`ifdef LIFT_CTRL_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  lift_req_scan #(
    .NUM_FLOORS (NUM_FLOORS)
  ) u_scan (
    .pending   (pending_q),
    .cur_floor (floor_q),
    .any_above (any_above),
    .any_below (any_below),
    .hit       (hit)
  );

  // Next pending vector: latch new requests, drop the floor being served.
  // On the arrival edge the served floor is the one being stepped onto.
  always_comb begin
    arrive     = (state_q == MOVE) && (timer_q == '0);
    step_floor = (dir_q == DIR_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    enter_door = ((state_q == IDLE) && hit) || (arrive && pending_q[step_floor]);
    clear_mask = '0;
    if (enter_door || (state_q == DOOR)) begin
      clear_mask = NUM_FLOORS'(1) << (arrive ? step_floor : floor_q);
    end
    pending_d = (pending_q | req_vec) & ~clear_mask;
  end

  // SCAN FSM with travel/door timer, floor, direction and pending registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      floor_q   <= '0;
      dir_q     <= DIR_UP;
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (hit) begin
            state_q <= DOOR;
            timer_q <= DOOR_RELOAD;
          end else if (pending_q != '0) begin
            dir_q   <= (any_above && ((dir_q == DIR_UP) || !any_below)) ? DIR_UP : DIR_DOWN;
            state_q <= MOVE;
            timer_q <= MOVE_RELOAD;
          end
        end
        MOVE: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TIMER_W'(1);
          end else begin
            floor_q <= step_floor;
            if (pending_q[step_floor]) begin
              state_q <= DOOR;
              timer_q <= DOOR_RELOAD;
            end else begin
              timer_q <= MOVE_RELOAD;
            end
          end
        end
        DOOR: begin
          if (hold) begin
            timer_q <= DOOR_RELOAD;
          end else if (timer_q != '0) begin
            timer_q <= timer_q - TIMER_W'(1);
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cur_floor    = floor_q;
  assign floor_onehot = NUM_FLOORS'(1) << floor_q;
  assign dir_up       = dir_q;
  assign moving       = (state_q == MOVE);
  assign door_open    = (state_q == DOOR);
  assign pending      = pending_q;

endmodule

// File: tb/tb_lift_ctrl_n.sv
// Self-checking bench for lift_ctrl_n: a cycle-level behavioural model
// (counters of remaining travel/door cycles) checked every cycle, plus
// hand-computed literal timing expectations.
module tb_lift_ctrl_n;

  localparam int NF = 8;
  localparam int MC = 4;
  localparam int DC = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NF-1:0] req_vec = '0;
  logic [2:0]    cur_floor;
  logic [NF-1:0] floor_onehot;
  logic          dir_up;
  logic          moving;
  logic          door_open;
  logic [NF-1:0] pending;
`ifdef LIFT_CTRL_HOLD_EN
  logic          door_hold = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  lift_ctrl_n #(
    .NUM_FLOORS  (NF),
    .MOVE_CYCLES (MC),
    .DOOR_CYCLES (DC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef LIFT_CTRL_HOLD_EN
    .door_hold    (door_hold),
`endif
    .req_vec      (req_vec),
    .cur_floor    (cur_floor),
    .floor_onehot (floor_onehot),
    .dir_up       (dir_up),
    .moving       (moving),
    .door_open    (door_open),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: car position, direction, requests, and remaining
  // cycles of travel to the next floor or of door-open time.
  int            m_floor;
  bit            m_dir;
  int            m_travel_left;
  int            m_door_left;
  logic [NF-1:0] m_pend;

  always @(posedge clk or posedge rst) begin
    logic [NF-1:0] nxt;
    bit above, below, hold;
    if (rst) begin
      m_floor = 0; m_dir = 1; m_travel_left = 0; m_door_left = 0; m_pend = '0;
    end else begin
`ifdef LIFT_CTRL_HOLD_EN
      hold = door_hold;
`else
      hold = 0;
`endif
      nxt = m_pend | req_vec;
      if (m_door_left > 0) begin
        nxt[m_floor] = 1'b0;
        if (hold) m_door_left = DC;
        else m_door_left = m_door_left - 1;
      end else if (m_travel_left > 0) begin
        m_travel_left = m_travel_left - 1;
        if (m_travel_left == 0) begin
          m_floor = m_dir ? m_floor + 1 : m_floor - 1;
          if (m_pend[m_floor]) begin
            nxt[m_floor] = 1'b0;
            m_door_left = DC;
          end else begin
            m_travel_left = MC;
          end
        end
      end else if (m_pend != '0) begin
        if (m_pend[m_floor]) begin
          nxt[m_floor] = 1'b0;
          m_door_left = DC;
        end else begin
          above = 0; below = 0;
          for (int f = 0; f < NF; f++) begin
            if (m_pend[f] && f > m_floor) above = 1;
            if (m_pend[f] && f < m_floor) below = 1;
          end
          m_dir = above && (m_dir || !below);
          m_travel_left = MC;
        end
      end
      m_pend = nxt;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cur_floor",    32'(cur_floor),    32'(m_floor));
      chk("floor_onehot", 32'(floor_onehot), 32'(1) << m_floor);
      chk("dir_up",       32'(dir_up),       32'(m_dir));
      chk("moving",       32'(moving),       32'(m_travel_left > 0));
      chk("door_open",    32'(door_open),    32'(m_door_left > 0));
      chk("pending",      32'(pending),      32'(m_pend));
    end
  end

  // One-cycle request pulse sampled by the following rising edge (edge k);
  // returns on the falling edge after edge k.
  task automatic pulse(input logic [NF-1:0] r);
    @(negedge clk); req_vec = r;
    @(negedge clk); req_vec = '0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_door(input int f, input int budget, input string name);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk); #1;
      if (door_open && int'(cur_floor) == f) found = 1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  task automatic wait_closed(input int budget, input string name);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk); #1;
      if (!door_open) found = 1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    cmp_en = 1;
    step(2);
    @(negedge clk) rst = 1'b0;

    // Idle after reset.
    step(10);
    chk("idle_floor",  32'(cur_floor),    32'd0);
    chk("idle_onehot", 32'(floor_onehot), 32'h01);
    chk("idle_door",   32'(door_open),    32'd0);

    // Floor 0 -> 3: motion at k+1, door at k+13, closed at k+19.
    pulse(8'h08);
    step(1);  chk("f3_moving", 32'(moving), 32'd1);
    step(12); chk("f3_floor",  32'(cur_floor), 32'd3);
    chk("f3_door_open", 32'(door_open), 32'd1);
    step(5);  chk("f3_door_k18", 32'(door_open), 32'd1);
    step(1);  chk("f3_door_closed", 32'(door_open), 32'd0);
    chk("f3_pending", 32'(pending), 32'd0);

    // From 3 heading to 6; requests 1 and 5 arrive between floors 3 and 4.
    pulse(8'h40);
    step(2);
    pulse(8'h22);
    step(6);
    chk("scan_stop5_floor", 32'(cur_floor), 32'd5);
    chk("scan_stop5_door",  32'(door_open), 32'd1);
    wait_door(6, 40, "scan_arrive6");
    chk("scan_dir_at6", 32'(dir_up), 32'd1);
    wait_closed(20, "scan_close6");
    step(1);
    chk("scan_rev_moving", 32'(moving), 32'd1);
    chk("scan_rev_dir",    32'(dir_up), 32'd0);
    wait_door(1, 60, "scan_arrive1");
    chk("scan_dir_at1", 32'(dir_up), 32'd0);
    wait_closed(20, "scan_close1");

    // Tie at floor 1 (requests 0 and 6) resolves to the held down direction.
    pulse(8'h41);
    step(1); chk("tie_dir", 32'(dir_up), 32'd0);
    step(4); chk("tie_floor0", 32'(cur_floor), 32'd0);
    chk("tie_door0", 32'(door_open), 32'd1);
    wait_closed(20, "tie_close0");
    step(1); chk("bottom_dir_up", 32'(dir_up), 32'd1);
    wait_door(6, 60, "tie_arrive6");
    wait_closed(20, "tie_close6");

    // Go to floor 4, then request the current floor while idle.
    pulse(8'h10);
    wait_door(4, 40, "to4_arrive");
    wait_closed(20, "to4_close");
    pulse(8'h10);
    step(1); chk("here_door_k1", 32'(door_open), 32'd1);
    pulse(8'h10);
    chk("here_repulse_pending", 32'(pending), 32'd0);
    step(4); chk("here_door_k6", 32'(door_open), 32'd1);
    step(1); chk("here_door_k7", 32'(door_open), 32'd0);
    chk("here_pending_end", 32'(pending), 32'd0);

    // Reset while moving between floors 2 and 3 with floor 7 pending.
    pulse(8'h04);
    wait_door(2, 40, "to2_arrive");
    wait_closed(20, "to2_close");
    pulse(8'h80);
    step(3);
    chk("pre_rst_pending", 32'(pending), 32'h80);
    chk("pre_rst_moving",  32'(moving),  32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_floor",   32'(cur_floor),    32'd0);
    chk("rst_onehot",  32'(floor_onehot), 32'h01);
    chk("rst_dir",     32'(dir_up),       32'd1);
    chk("rst_moving",  32'(moving),       32'd0);
    chk("rst_door",    32'(door_open),    32'd0);
    chk("rst_pending", 32'(pending),      32'd0);
    step(2);
    @(negedge clk) rst = 1'b0;
    step(10);
    chk("post_rst_moving", 32'(moving),    32'd0);
    chk("post_rst_floor",  32'(cur_floor), 32'd0);

`ifdef LIFT_CTRL_HOLD_EN
    // Hold the door 20 clocks, then it closes on the 6th edge after release.
    begin
      int close_at = 0;
      pulse(8'h01);
      door_hold = 1'b1;
      for (int i = 0; i < 20; i++) begin
        step(1);
        chk("hold_open", 32'(door_open), 32'd1);
      end
      @(negedge clk) door_hold = 1'b0;
      for (int i = 1; i <= 20 && close_at == 0; i++) begin
        step(1);
        if (!door_open) close_at = i;
      end
      chk("hold_release_close", 32'(close_at), 32'd6);
    end
`endif

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
